// File: rtl/select_pkg.sv
// select_pkg: shared constants, scheduler state type and the 2-bit select rule
//   NREQ_DEF, W_DEF : default requester count and datapath width
//   state_t         : scheduler FSM states
//   select_fn       : Z = A if (A>B or C<D), else C if C>D, else (A+B) mod 2^W
package select_pkg;
   localparam int NREQ_DEF = 4;
   localparam int W_DEF = 2;
   typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;
   function automatic logic [W_DEF-1:0] select_fn(
      input logic [W_DEF-1:0] a, b, c, d
   );
      return (a > b || c < d) ? a : (c > d) ? c : a + b;
   endfunction
endpackage

// File: rtl/select_sched_if.sv
// select_sched_if: requester/consumer bundle of the select scheduler
//   req, op_a..op_d, z_ready : driven by requesters/consumer (master)
//   gnt, z, z_id, z_valid, busy : driven by the scheduler (slave)
interface select_sched_if
   import select_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W = W_DEF
);
   logic [NREQ-1:0] req;
   logic [NREQ*W-1:0] op_a, op_b, op_c, op_d;
   logic [NREQ-1:0] gnt;
   logic [W-1:0] z;
   logic [$clog2(NREQ)-1:0] z_id;
   logic z_valid;
   logic z_ready;
   logic busy;
   modport master(
      output req, op_a, op_b, op_c, op_d, z_ready,
      input gnt, z, z_id, z_valid, busy
   );
   modport slave(
      input req, op_a, op_b, op_c, op_d, z_ready,
      output gnt, z, z_id, z_valid, busy
   );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
//   req : request vector     ptr : search start index
//   gnt : one-hot winner     idx : winner index (0 when no request)
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IW = $clog2(NREQ)
) (
   input logic [NREQ-1:0] req,
   input logic [IW-1:0] ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0] idx
);
   always_comb begin
      idx = '0;
      // scan from farthest to nearest so the nearest set bit wins last
      for (int k = NREQ - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % NREQ]) idx = IW'((int'(ptr) + k) % NREQ);
      gnt = |req ? NREQ'(1) << idx : '0;
   end
endmodule

// File: rtl/select_sched.sv
// select_sched: round-robin shares one registered select datapath among NREQ requesters
//   clk, reset : clock and synchronous active-high reset
//   bus        : req/op_* in, one-hot gnt pulse, z/z_id/z_valid result with z_ready, busy
module select_sched
   import select_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W = W_DEF,
   localparam int IW = $clog2(NREQ)
) (
   input logic clk,
   input logic reset,
   select_sched_if.slave bus
);
   state_t state;
   logic [IW-1:0] ptr, cap_id, arb_idx;
   logic [NREQ-1:0] arb_gnt;
   logic [W-1:0] ca, cb, cc, cd;
   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req(bus.req),
      .ptr(ptr),
      .gnt(arb_gnt),
      .idx(arb_idx)
   );
   assign bus.busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ptr <= '0;
         cap_id <= '0;
         ca <= '0;
         cb <= '0;
         cc <= '0;
         cd <= '0;
         bus.gnt <= '0;
         bus.z <= '0;
         bus.z_id <= '0;
         bus.z_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (|bus.req) begin
               bus.gnt <= arb_gnt;
               cap_id <= arb_idx;
               ca <= bus.op_a[arb_idx*W +: W];
               cb <= bus.op_b[arb_idx*W +: W];
               cc <= bus.op_c[arb_idx*W +: W];
               cd <= bus.op_d[arb_idx*W +: W];
               state <= EVAL;
            end
            EVAL: begin
               bus.z <= select_fn(ca, cb, cc, cd);
               bus.z_id <= cap_id;
               bus.z_valid <= 1'b1;
               bus.gnt <= '0;
               state <= HOLD;
            end
            HOLD: if (bus.z_ready) begin
               // pointer moves only once the result has been taken
               bus.z_valid <= 1'b0;
               ptr <= cap_id == IW'(NREQ - 1) ? '0 : cap_id + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_select_sched.sv
// tb_select_sched: directed and random checks of select_sched against a transaction model
module tb_select_sched;
   localparam int N = 4;
   logic clk = 0;
   logic reset = 1;
   int total = 0;
   int bad = 0;
   bit run = 0;
   select_sched_if #(.NREQ(N), .W(2)) bus ();
   select_sched #(.NREQ(N), .W(2)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   // transaction model: ph 0 = waiting, 1 = granted, 2 = result offered
   int ph = 0, ptr = 0, win = 0, ma, mb, mc, md, m_z = 0, m_id = 0;
   bit fresh = 1;

   function automatic int rule(int a, int b, int c, int d);
      if (a > b || c < d) return a;
      if (c > d) return c;
      return (a + b) % 4;
   endfunction

   function automatic int fld(logic [N*2-1:0] v, int i);
      return int'((v >> (i * 2)) & 3);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         ph = 0; ptr = 0; fresh = 1; m_z = 0; m_id = 0;
      end else if (ph == 0) begin
         for (int k = 0; k < N; k++)
            if (ph == 0 && bus.req[(ptr + k) % N]) begin
               win = (ptr + k) % N;
               ma = fld(bus.op_a, win); mb = fld(bus.op_b, win);
               mc = fld(bus.op_c, win); md = fld(bus.op_d, win);
               ph = 1;
            end
      end else if (ph == 1) begin
         m_z = rule(ma, mb, mc, md); m_id = win; fresh = 0; ph = 2;
      end else if (bus.z_ready) begin
         ptr = (win + 1) % N; ph = 0;
      end
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) if (run) begin
      chk("m_gnt", bus.gnt, ph == 1 ? 32'(1) << win : 0);
      chk("m_z_valid", bus.z_valid, ph == 2);
      chk("m_busy", bus.busy, ph != 0);
      if (ph == 2 || fresh) begin
         chk("m_z", bus.z, m_z);
         chk("m_z_id", bus.z_id, m_id);
      end
   end

   task automatic step(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_op(int i, int a, int b, int c, int d);
      bus.op_a[i*2 +: 2] = 2'(a);
      bus.op_b[i*2 +: 2] = 2'(b);
      bus.op_c[i*2 +: 2] = 2'(c);
      bus.op_d[i*2 +: 2] = 2'(d);
   endtask

   task automatic one(int i, int a, int b, int c, int d, int exp);
      set_op(i, a, b, c, d);
      bus.req = 4'(1 << i);
      step();
      chk("d_gnt", bus.gnt, 1 << i);
      bus.req = 0;
      step();
      chk("d_z", bus.z, exp);
      chk("d_z_id", bus.z_id, i);
      step();
   endtask

   task automatic all_zero(string tag);
      chk({tag, "_gnt"}, bus.gnt, 0);
      chk({tag, "_z"}, bus.z, 0);
      chk({tag, "_z_id"}, bus.z_id, 0);
      chk({tag, "_z_valid"}, bus.z_valid, 0);
      chk({tag, "_busy"}, bus.busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      bus.req = 0; bus.z_ready = 0;
      bus.op_a = 0; bus.op_b = 0; bus.op_c = 0; bus.op_d = 0;
      step(3);
      run = 1;
      reset = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         all_zero("rst");
      end
      // requester 0 alone
      set_op(0, 2, 1, 0, 0);
      bus.z_ready = 1;
      bus.req = 4'b0001;
      step();
      chk("r0_gnt", bus.gnt, 4'b0001);
      bus.req = 0;
      step();
      chk("r0_z_valid", bus.z_valid, 1);
      chk("r0_z", bus.z, 2);
      chk("r0_z_id", bus.z_id, 0);
      step();
      chk("r0_drop", bus.z_valid, 0);
      // rule branches on requester 2
      one(2, 1, 1, 3, 2, 3);
      one(2, 3, 3, 1, 1, 2);
      one(2, 0, 1, 2, 3, 0);
      // all requesting: rotation from pointer 0
      reset = 1;
      step();
      reset = 0;
      bus.op_a = 8'($urandom); bus.op_b = 8'($urandom);
      bus.op_c = 8'($urandom); bus.op_d = 8'($urandom);
      bus.req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         step();
         chk("rr_gnt", bus.gnt, 1 << (g % 4));
         step();
         chk("rr_z_id", bus.z_id, g % 4);
         step();
      end
      bus.req = 0;
      step(2);
      // stall in HOLD
      set_op(0, 1, 2, 3, 3);
      bus.z_ready = 0;
      bus.req = 4'b0001;
      step();
      chk("st_gnt", bus.gnt, 4'b0001);
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("st_valid", bus.z_valid, 1);
         chk("st_z", bus.z, 3);
         chk("st_z_id", bus.z_id, 0);
         chk("st_gnt0", bus.gnt, 0);
         chk("st_busy", bus.busy, 1);
      end
      bus.z_ready = 1;
      step();
      chk("st_drop", bus.z_valid, 0);
      chk("st_gnt_idle", bus.gnt, 0);
      step();
      chk("st_next_gnt", bus.gnt, 4'b0001);
      bus.req = 0;
      step(2);
      // reset while holding a result
      bus.z_ready = 0;
      bus.req = 4'b0001;
      step();
      bus.req = 0;
      step();
      chk("hr_valid", bus.z_valid, 1);
      reset = 1;
      step();
      all_zero("hr");
      reset = 0;
      bus.req = 4'b0110;
      step();
      chk("hr_gnt", bus.gnt, 4'b0010);
      bus.req = 0;
      bus.z_ready = 1;
      step(3);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         bus.req = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'b0000;
         bus.op_a = 8'($urandom); bus.op_b = 8'($urandom);
         bus.op_c = 8'($urandom); bus.op_d = 8'($urandom);
         bus.z_ready = $urandom_range(0, 2) != 0;
         reset = $urandom_range(0, 59) == 0;
         step();
      end
      reset = 0; bus.req = 0; bus.z_ready = 1;
      step(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/select_sched.md
# select_sched

Round-robin scheduler that shares one registered instance of the team's 2-bit select datapath among NREQ requesters. It arbitrates requests, captures the winner's A/B/C/D operands and evaluates the select rule. It then returns Z with the requester's index over a valid/ready handshake. It sits between the requesting units and the select function, and is the only path by which that function is evaluated.

## Interface
- NREQ, 4: number of requesters; must be ≥ 2.
- W, 2: operand and result width.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- op_a, op_b, op_c, op_d  in  NREQ*W each  flattened operands; requester i uses bits [i*W +: W].
- gnt  out  NREQ  one-hot grant pulse, one cycle wide.
- z  out  W  result.
- z_id  out  $clog2(NREQ)  index of the requester that owns z.
- z_valid  out  1  result valid.
- z_ready  in  1  consumer accepts the result.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EVAL, HOLD.
- IDLE, any req bit set: choose the winner.
  - The winner is the first set bit at or after the round-robin pointer, scanning upward with wrap.
  - Register gnt to one-hot(winner), capture the winner's four operands and its index, then go to EVAL.
- IDLE, req == 0: stay in IDLE; gnt stays 0.
- EVAL: compute the select rule on the captured operands.
  - Register z and z_id, set z_valid, clear gnt, go to HOLD.
- Select rule, unsigned compares:
  - if (A>B or C<D), Z=A;
  - else if C>D, Z=C;
  - else Z=(A+B) mod 2^W, with the carry discarded.
- HOLD: keep z, z_id and z_valid stable until z_ready=1 at a clock edge.
  - On that edge: clear z_valid, set pointer = (winner+1) mod NREQ, go to IDLE.
- req is sampled only in IDLE. A requester that drops req before it is granted is simply not served. After a grant, operands are captured, so later changes to req or operands have no effect on the pending result.
- Reset values:
  - gnt=0, z=0, z_id=0, z_valid=0, busy=0;
  - state=IDLE, pointer=0.
- Reset mid-operation (in EVAL or HOLD): the pending transaction is dropped with no z_valid. Reset takes priority over every other event in the same cycle.

## Timing
- Cycle n: IDLE and req≠0 are sampled.
- Cycle n+1: gnt is high (one cycle only); state is EVAL.
- Cycle n+2: z_valid=1, and z and z_id are valid.
- Each cycle with z_ready=0 in HOLD extends the transaction by one cycle.
- If z_ready=1 during cycle n+2, z_valid is 0 in n+3 and a new request can be sampled in n+3.
- Peak throughput is one result per 3 cycles. No combinational path exists from req, op_* or z_ready to any output.
- The pointer advances only on a completed handshake, never on a grant alone.

## Structure
- Package select_pkg holds:
  - default W and NREQ constants;
  - the state enum {IDLE, EVAL, HOLD};
  - a function select_fn(a,b,c,d) implementing the select rule, shared with any other user of the datapath.
- Sub-module rr_arbiter (req, pointer → one-hot grant and index) is purely combinational and is instantiated once.
- The FSM, operand capture and result registers live in select_sched itself.

## Test plan
- Reset held, then released with req=0 → all outputs 0 and busy=0 for 10 cycles.
- Requester 0 only, A=2, B=1, C=0, D=0, z_ready=1:
  - gnt=0001 in cycle n+1;
  - z=2, z_id=0 and z_valid in n+2.
- Rule branches on requester 2:
  - A=1, B=1, C=3, D=2 → z=3.
  - A=3, B=3, C=1, D=1 → z=2 (6 mod 4).
  - A=0, B=1, C=2, D=3 → z=0.
- req=1111 held, z_ready=1:
  - grants 0,1,2,3,0 in order, one every 3 cycles;
  - z_id matches each grant.
- z_ready=0 for 5 cycles in HOLD → z_valid, z and z_id stay stable, no gnt, busy=1. On z_ready=1 → z_valid drops and the next grant follows.
- reset asserted in HOLD with z_valid=1 → next cycle all outputs 0 and pointer 0. With req=0110 afterwards, requester 1 is granted first.
